// File: rtl/timeout_event_monitor.sv
// rtl/timeout_event_monitor.sv - timestamped timeout-edge event recorder with FIFO drain port
// Rising edges of timeout are recorded as {dn_up, cntout, ts} in a first-word fall-through FIFO.
module timeout_event_monitor #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       timeout,
  input  logic [3:0]                 cntout,
  input  logic                       dn_up,
  input  logic                       clr,
  input  logic                       ev_ready,
  output logic                       ev_valid,
  output logic [TS_W+4:0]            ev_data,
  output logic [$clog2(DEPTH):0]     ev_level,
  output logic [7:0]                 ev_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 5;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] ts;
  logic            timeout_q;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            ev_det;
  logic            pop;
  logic            push;
  logic            drop;
  logic [RW-1:0]   new_rec;
  logic [AW-1:0]   rd_nxt;
  logic [AW:0]     level_nxt;
  logic [RW-1:0]   head_nxt;

  assign ev_valid = (ev_level != '0);

  always_comb begin
    ev_det    = timeout & ~timeout_q;
    pop       = ev_valid & ev_ready;
    push      = ev_det & ((ev_level != FULL_LEVEL) | pop);
    drop      = ev_det & (ev_level == FULL_LEVEL) & ~pop;
    new_rec   = {dn_up, cntout, ts};
    rd_nxt    = rd_ptr + AW'(pop);
    level_nxt = ev_level + (AW+1)'(push) - (AW+1)'(pop);
    // The incoming record becomes the head only when nothing older survives this edge.
    if (push && ((ev_level == '0) || ((ev_level == (AW+1)'(1)) && pop)))
      head_nxt = new_rec;
    else
      head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push && !clr)
      mem[wr_ptr] <= new_rec;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ts        <= '0;
      timeout_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ev_level  <= '0;
      ev_data   <= '0;
      ev_count  <= '0;
      overflow  <= 1'b0;
    end else begin
      ts        <= ts + TS_W'(1);
      timeout_q <= timeout;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ev_level <= '0;
        ev_count <= '0;
        overflow <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        rd_ptr   <= rd_nxt;
        ev_level <= level_nxt;
        // ev_data keeps the last head once the FIFO runs empty.
        if (level_nxt != '0)
          ev_data <= head_nxt;
        if (ev_det && (ev_count != 8'hFF))
          ev_count <= ev_count + 8'd1;
        if (drop)
          overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timeout_event_monitor.sv
// tb/tb_timeout_event_monitor.sv - randomized and directed bench against a queue-based event model
module tb_timeout_event_monitor;

  localparam int DEPTH = 4;
  localparam int TS_W  = 8;

  logic        clk;
  logic        n_reset;
  logic        timeout;
  logic [3:0]  cntout;
  logic        dn_up;
  logic        clr;
  logic        ev_ready;
  logic        ev_valid;
  logic [12:0] ev_data;
  logic [2:0]  ev_level;
  logic [7:0]  ev_count;
  logic        overflow;

  timeout_event_monitor #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .timeout  (timeout),
    .cntout   (cntout),
    .dn_up    (dn_up),
    .clr      (clr),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .ev_level (ev_level),
    .ev_count (ev_count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [12:0] m_q[$];
  int          m_cnt;
  bit          m_ovf;
  int          m_ts;
  bit          m_prev;
  logic [12:0] m_last;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt  = 0;
    m_ovf  = 0;
    m_ts   = 0;
    m_prev = 0;
    m_last = '0;
  endtask

  task automatic check_all();
    check_val("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
    check_val("ev_data",  32'(ev_data),  32'(m_q.size() != 0 ? m_q[0] : m_last));
    check_val("ev_level", 32'(ev_level), 32'(m_q.size()));
    check_val("ev_count", 32'(ev_count), 32'(m_cnt));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive, apply the edge to the model, compare on the falling edge.
  task automatic tick(input bit t, input logic [3:0] c, input bit d, input bit r, input bit cl);
    bit ev;
    bit pp;
    timeout  = t;
    cntout   = c;
    dn_up    = d;
    ev_ready = r;
    clr      = cl;
    @(posedge clk);
    ev = t && !m_prev;
    pp = r && (m_q.size() != 0);
    if (cl) begin
      m_q.delete();
      m_cnt = 0;
      m_ovf = 0;
    end else begin
      if (pp) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() < DEPTH) m_q.push_back({d, c, 8'(m_ts)});
        else m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (m_q.size() != 0) m_last = m_q[0];
    m_prev = t;
    m_ts   = (m_ts + 1) % 256;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    n_reset  = 1'b0;
    timeout  = 1'b0;
    cntout   = 4'd0;
    dn_up    = 1'b0;
    clr      = 1'b0;
    ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    n_reset = 1'b1;

    // Single event at ts = 5, held high three cycles.
    repeat (5) tick(0, 4'd0, 0, 0, 0);
    tick(1, 4'hC, 1, 0, 0);
    check_val("single_data",  32'(ev_data),  32'(13'h1C05));
    check_val("single_level", 32'(ev_level), 32'd1);
    tick(1, 4'hC, 1, 0, 0);
    tick(1, 4'hC, 1, 0, 0);
    check_val("single_count", 32'(ev_count), 32'd1);

    // Overflow: six pulses into a depth-4 FIFO with no draining.
    tick(0, 4'd0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      tick(1, 4'(i + 1), i[0], 0, 0);
      tick(0, 4'd0, 0, 0, 0);
    end
    check_val("ovf_level", 32'(ev_level), 32'd4);
    check_val("ovf_count", 32'(ev_count), 32'd6);
    check_val("ovf_flag",  32'(overflow), 32'd1);

    // Full with simultaneous pop and push.
    tick(1, 4'd7, 0, 1, 0);
    check_val("fullpp_level", 32'(ev_level), 32'd4);
    check_val("fullpp_ovf",   32'(overflow), 32'd1);

    // Drain under backpressure.
    tick(0, 4'd0, 0, 1, 0);
    tick(0, 4'd0, 0, 0, 0);
    tick(0, 4'd0, 0, 1, 0);
    tick(0, 4'd0, 0, 0, 0);
    tick(0, 4'd0, 0, 1, 0);
    tick(0, 4'd0, 0, 1, 0);
    check_val("drain_valid", 32'(ev_valid), 32'd0);

    // Saturation at 255, then clr coinciding with an edge.
    for (int i = 0; i < 300; i++) begin
      tick(1, 4'($urandom), 1'($urandom), 1, 0);
      tick(0, 4'd0, 0, 1, 0);
    end
    check_val("sat_count", 32'(ev_count), 32'd255);
    tick(1, 4'd3, 1, 0, 1);
    check_val("clr_count", 32'(ev_count), 32'd0);
    check_val("clr_level", 32'(ev_level), 32'd0);
    check_val("clr_ovf",   32'(overflow), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      tick(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 63) == 0));

    // Reset between edges with three entries queued.
    tick(0, 4'd0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 4'(i + 9), 1, 0, 0);
      tick(0, 4'd0, 0, 0, 0);
    end
    check_val("pre_rst_level", 32'(ev_level), 32'd3);
    #2 n_reset = 1'b0;
    #1;
    check_val("rst_valid", 32'(ev_valid), 32'd0);
    check_val("rst_data",  32'(ev_data),  32'd0);
    check_val("rst_level", 32'(ev_level), 32'd0);
    check_val("rst_count", 32'(ev_count), 32'd0);
    check_val("rst_ovf",   32'(overflow), 32'd0);
    model_reset();
    timeout = 1'b1;
    #1 n_reset = 1'b1;
    tick(1, 4'd5, 0, 0, 0);
    check_val("post_rst_valid", 32'(ev_valid), 32'd1);
    check_val("post_rst_data",  32'(ev_data),  32'(13'h0500));
    for (int i = 0; i < 200; i++)
      tick(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
